// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank: channel modes and default ratios.
package clk_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int unsigned CFG_CH_W = 4;
  localparam int unsigned SYS_CLK_HZ = 100_000_000;

  // Half-period divider for a square wave of out_hz derived from clk_hz.
  function automatic int unsigned half_period_div(input int unsigned clk_hz,
                                                  input int unsigned out_hz);
    return clk_hz / (2 * out_hz);
  endfunction

  localparam int unsigned DIV_480HZ = half_period_div(SYS_CLK_HZ, 480);
  localparam int unsigned DIV_1KHZ  = half_period_div(SYS_CLK_HZ, 1000);

endpackage

// File: rtl/clk_div_ch.sv
// Single divider channel: counter, active/pending config, tick and clk_out.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DEF_DIV  = DIV_480HZ,
  parameter logic        DEF_MODE = MODE_TOGGLE
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             cfg_pend,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_a, div_a_n;
  logic [CNT_W-1:0] div_p, div_p_n;
  logic             mode_a, mode_a_n;
  logic             mode_p, mode_p_n;
  logic             pend_n, clk_n, tick_n;
  logic             running, at_tc, apply;

  // Next-state: counting, terminal count, config apply and sync restart.
  always_comb begin
    cnt_n    = cnt;
    div_a_n  = div_a;
    div_p_n  = div_p;
    mode_a_n = mode_a;
    mode_p_n = mode_p;
    pend_n   = cfg_pend;
    clk_n    = clk_out;
    tick_n   = 1'b0;

    running = en && (div_a != '0);
    at_tc   = running && (cnt == div_a - CNT_W'(1));
    // Apply only where no output edge can be cut short: at TC or while idle.
    apply   = cfg_pend && (at_tc || !en || (div_a == '0));

    if (sync) begin
      cnt_n = '0;
      clk_n = 1'b0;
      if (cfg_we) begin
        div_a_n  = cfg_div;
        mode_a_n = cfg_mode;
        div_p_n  = cfg_div;
        mode_p_n = cfg_mode;
      end else if (cfg_pend) begin
        div_a_n  = div_p;
        mode_a_n = mode_p;
      end
      pend_n = 1'b0;
    end else begin
      if (running) begin
        if (at_tc) begin
          cnt_n  = '0;
          tick_n = 1'b1;
          if (mode_a == MODE_TOGGLE) begin
            clk_n = ~clk_out;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      if (apply) begin
        div_a_n  = div_p;
        mode_a_n = mode_p;
        pend_n   = 1'b0;
        // Restart from zero so a shrinking ratio can never overrun the compare.
        cnt_n    = '0;
        if (mode_p == MODE_PULSE) begin
          clk_n = 1'b0;
        end
      end
      // A write coinciding with an apply stays pending for the next one.
      if (cfg_we) begin
        div_p_n  = cfg_div;
        mode_p_n = cfg_mode;
        pend_n   = 1'b1;
      end
    end
  end

  // Channel state register with synchronous reset to the default config.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt      <= '0;
      div_a    <= CNT_W'(DEF_DIV);
      div_p    <= CNT_W'(DEF_DIV);
      mode_a   <= DEF_MODE;
      mode_p   <= DEF_MODE;
      cfg_pend <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      div_a    <= div_a_n;
      div_p    <= div_p_n;
      mode_a   <= mode_a_n;
      mode_p   <= mode_p_n;
      cfg_pend <= pend_n;
      clk_out  <= clk_n;
      tick     <= tick_n;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel clock divider / tick generator with shared config port and sync.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DEF_DIV  = DIV_480HZ,
  parameter logic        DEF_MODE = MODE_TOGGLE
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   en,
  input  logic                sync,
  input  logic                cfg_we,
  input  logic [CFG_CH_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic                cfg_mode,
  output logic [NUM_CH-1:0]   cfg_pend,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick
);

  logic [NUM_CH-1:0] ch_we_c;

  // Decode the channel index; indices at or above NUM_CH match nothing.
  always_comb begin
    ch_we_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_we_c[i] = cfg_we && (cfg_ch == CFG_CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV),
      .DEF_MODE(DEF_MODE)
    ) u_ch (
      .clk_in  (clk_in),
      .reset   (reset),
      .en      (en[g]),
      .sync    (sync),
      .cfg_we  (ch_we_c[g]),
      .cfg_div (cfg_div),
      .cfg_mode(cfg_mode),
      .cfg_pend(cfg_pend[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank; expectations queued by stimulus, checked by monitor.
module tb_clk_div_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int K_TICK = 0;
  localparam int K_CLK  = 1;
  localparam int K_PEND = 2;

  typedef struct {
    int    cyc;
    int    kind;
    int    ch;
    bit    val;
    string name;
  } exp_t;

  logic              clk_in = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_we;
  logic [3:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic [NUM_CH-1:0] cfg_pend;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  clk_div_bank #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (5),
    .DEF_MODE(1'b0)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_mode(cfg_mode),
    .cfg_pend(cfg_pend),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic pick(input int k, input int c);
    case (k)
      K_TICK:  return tick[c];
      K_CLK:   return clk_out[c];
      default: return cfg_pend[c];
    endcase
  endfunction

  // Monitor: compare every queued expectation due in the current cycle.
  always @(negedge clk_in) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        logic act;
        act = pick(q[i].kind, q[i].ch);
        total++;
        if (act !== q[i].val) begin
          bad++;
          $display("FAIL %s ch%0d cyc=%0d actual=%b required=%b",
                   q[i].name, q[i].ch, cyc, act, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic ex(input int c, input int k, input int ch, input bit v, input string n);
    exp_t e;
    e.cyc = c; e.kind = k; e.ch = ch; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc != c) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic cfg(input bit we, input int ch, input int dv, input bit md);
    cfg_we   = we;
    cfg_ch   = 4'(ch);
    cfg_div  = CNT_W'(dv);
    cfg_mode = md;
  endtask

  initial begin
    reset = 1'b1; en = '0; sync = 1'b0;
    cfg(1'b0, 0, 0, 1'b0);
    for (int c = 0; c < NUM_CH; c++) begin
      ex(2, K_TICK, c, 1'b0, "rst_tick");
      ex(2, K_CLK,  c, 1'b0, "rst_clk");
      ex(2, K_PEND, c, 1'b0, "rst_pend");
    end

    // Default divider 5 on channel 0: first rise after 5 cycles, period 10.
    wait_to(3);
    reset = 1'b0; en = 4'b0001;
    ex(7,  K_TICK, 0, 1'b0, "pre_tc_tick");  ex(7,  K_CLK, 0, 1'b0, "pre_tc_clk");
    ex(8,  K_TICK, 0, 1'b1, "tc1_tick");     ex(8,  K_CLK, 0, 1'b1, "tc1_clk");
    ex(9,  K_TICK, 0, 1'b0, "post_tc_tick"); ex(9,  K_CLK, 0, 1'b1, "post_tc_clk");
    ex(13, K_TICK, 0, 1'b1, "tc2_tick");     ex(13, K_CLK, 0, 1'b0, "tc2_clk");
    ex(18, K_TICK, 0, 1'b1, "tc3_tick");     ex(18, K_CLK, 0, 1'b1, "tc3_clk");

    // Disable channel 0 at cnt=3 for 7 cycles.
    wait_to(21);
    en = 4'b0000;
    ex(22, K_CLK,  0, 1'b1, "dis_clk_hold");
    ex(23, K_TICK, 0, 1'b0, "dis_no_tick");  ex(23, K_CLK, 0, 1'b1, "dis_clk_hold2");
    ex(26, K_TICK, 0, 1'b0, "dis_no_tick2"); ex(28, K_CLK, 0, 1'b1, "dis_clk_hold3");
    ex(29, K_TICK, 0, 1'b0, "resume_tick0"); ex(29, K_CLK, 0, 1'b1, "resume_clk0");
    ex(30, K_TICK, 0, 1'b1, "resume_tc");    ex(30, K_CLK, 0, 1'b0, "resume_tc_clk");
    wait_to(28);
    en = 4'b0001;

    // Write div 8 at cnt=2: pending until TC, then 8-cycle half period.
    wait_to(32);
    cfg(1'b1, 0, 8, 1'b0);
    ex(33, K_PEND, 0, 1'b1, "pend_set");  ex(34, K_PEND, 0, 1'b1, "pend_hold");
    ex(35, K_PEND, 0, 1'b0, "pend_clr");
    ex(35, K_TICK, 0, 1'b1, "old_tc_tick"); ex(35, K_CLK, 0, 1'b1, "old_tc_clk");
    ex(36, K_TICK, 0, 1'b0, "new_div_tick0");
    ex(42, K_TICK, 0, 1'b0, "no_short_tick"); ex(42, K_CLK, 0, 1'b1, "no_short_clk");
    ex(43, K_TICK, 0, 1'b1, "div8_tc_tick");  ex(43, K_CLK, 0, 1'b0, "div8_tc_clk");
    wait_to(33);
    cfg(1'b0, 0, 0, 1'b0);

    // Channel 1 pulse div 3, channel 2 toggle div 1 (applied while disabled).
    wait_to(43);
    cfg(1'b1, 1, 3, 1'b1);
    ex(44, K_PEND, 1, 1'b1, "ch1_pend"); ex(45, K_PEND, 1, 1'b0, "ch1_idle_apply");
    wait_to(44);
    cfg(1'b1, 2, 1, 1'b0);
    ex(45, K_PEND, 2, 1'b1, "ch2_pend"); ex(46, K_PEND, 2, 1'b0, "ch2_idle_apply");
    wait_to(45);
    cfg(1'b0, 0, 0, 1'b0);
    wait_to(46);
    en = 4'b0111;
    ex(47, K_TICK, 2, 1'b1, "div1_tick_a"); ex(47, K_CLK, 2, 1'b1, "div1_clk_a");
    ex(48, K_TICK, 2, 1'b1, "div1_tick_b"); ex(48, K_CLK, 2, 1'b0, "div1_clk_b");
    ex(49, K_CLK,  2, 1'b1, "div1_clk_c");
    ex(47, K_TICK, 1, 1'b0, "p3_tick_a"); ex(48, K_TICK, 1, 1'b0, "p3_tick_b");
    ex(49, K_TICK, 1, 1'b1, "p3_tick_c"); ex(49, K_CLK,  1, 1'b0, "pulse_clk_low");
    ex(50, K_TICK, 1, 1'b0, "p3_tick_d"); ex(52, K_TICK, 1, 1'b1, "p3_tick_e");
    ex(52, K_CLK,  1, 1'b0, "pulse_clk_low2");

    // Leave a pending write on channel 0, then sync with a write-through to channel 3.
    wait_to(53);
    cfg(1'b1, 0, 6, 1'b0);
    ex(54, K_PEND, 0, 1'b1, "pre_sync_pend"); ex(55, K_PEND, 0, 1'b1, "pre_sync_pend2");
    ex(56, K_PEND, 0, 1'b0, "sync_applies_pend");
    wait_to(54);
    cfg(1'b0, 0, 0, 1'b0);
    wait_to(55);
    sync = 1'b1; en = 4'b1111;
    cfg(1'b1, 3, 4, 1'b0);
    ex(56, K_CLK,  0, 1'b0, "sync_clk0");  ex(56, K_CLK,  2, 1'b0, "sync_clk2");
    ex(56, K_TICK, 2, 1'b0, "sync_tick2"); ex(56, K_TICK, 1, 1'b0, "sync_tick1");
    ex(56, K_PEND, 3, 1'b0, "wt_no_pend"); ex(57, K_PEND, 3, 1'b0, "wt_no_pend2");
    ex(57, K_TICK, 2, 1'b1, "sync_ch2_tick"); ex(57, K_CLK, 2, 1'b1, "sync_ch2_clk");
    ex(59, K_TICK, 3, 1'b0, "ch3_pre_tick"); ex(59, K_CLK, 3, 1'b0, "ch3_pre_clk");
    ex(60, K_TICK, 3, 1'b1, "ch3_tick4");    ex(60, K_CLK, 3, 1'b1, "ch3_clk4");
    ex(59, K_TICK, 1, 1'b1, "sync_ch1_tick");
    ex(61, K_TICK, 0, 1'b0, "div6_pre_tick");
    ex(62, K_TICK, 0, 1'b1, "div6_tick");   ex(62, K_CLK, 0, 1'b1, "div6_clk");
    wait_to(56);
    sync = 1'b0;
    cfg(1'b0, 0, 0, 1'b0);

    // Out-of-range channel index is ignored.
    wait_to(62);
    cfg(1'b1, 15, 7, 1'b1);
    for (int c = 0; c < NUM_CH; c++) ex(63, K_PEND, c, 1'b0, "bad_ch_ignored");
    ex(63, K_TICK, 3, 1'b0, "ch3_mid");
    ex(64, K_TICK, 3, 1'b1, "ch3_unchanged");

    // Divider 0 on channel 0: applied at TC, then stalled until rewritten to 2.
    wait_to(63);
    cfg(1'b1, 0, 0, 1'b0);
    ex(64, K_PEND, 0, 1'b1, "div0_pend"); ex(67, K_PEND, 0, 1'b1, "div0_pend_hold");
    ex(68, K_PEND, 0, 1'b0, "div0_applied");
    ex(68, K_TICK, 0, 1'b1, "div0_last_tick"); ex(68, K_CLK, 0, 1'b0, "div0_last_clk");
    ex(69, K_TICK, 0, 1'b0, "stall_tick");  ex(71, K_TICK, 0, 1'b0, "stall_tick2");
    ex(71, K_CLK,  0, 1'b0, "stall_clk");   ex(72, K_PEND, 0, 1'b0, "stall_no_pend");
    wait_to(64);
    cfg(1'b0, 0, 0, 1'b0);
    wait_to(72);
    cfg(1'b1, 0, 2, 1'b0);
    ex(73, K_PEND, 0, 1'b1, "stall_rewrite_pend");
    ex(74, K_PEND, 0, 1'b0, "stall_apply_next");
    ex(75, K_TICK, 0, 1'b0, "div2_pre_tick"); ex(75, K_CLK, 0, 1'b0, "div2_pre_clk");
    ex(76, K_TICK, 0, 1'b1, "div2_tick");     ex(76, K_CLK, 0, 1'b1, "div2_clk");
    ex(77, K_TICK, 0, 1'b0, "div2_gap");
    ex(78, K_TICK, 0, 1'b1, "div2_tick2");    ex(78, K_CLK, 0, 1'b0, "div2_clk2");
    wait_to(73);
    cfg(1'b0, 0, 0, 1'b0);

    wait_to(82);
    if (q.size() != 0) begin
      $display("FAIL unchecked_expectations actual=%0d required=0", q.size());
      bad += q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock divider / tick generator, next generation of the single fixed-ratio pixel clock divider. Each of `NUM_CH` channels divides `clk_in` by a run-time programmable ratio and produces either a 50 % square wave (toggle mode) or a one-cycle strobe (pulse mode). Sits beside the display and scan logic and supplies the display scan clock (default 480 Hz from 100 MHz), debounce ticks and refresh strobes from one block.

## Interface
- `NUM_CH`, 4, number of independent channels (1..16)
- `CNT_W`, 32, divider/counter width in bits
- `DEF_DIV`, 104166, divider loaded into every channel at reset (100 MHz / 480 Hz / 2)
- `DEF_MODE`, 0, mode loaded at reset (0 = toggle, 1 = pulse)

- `clk_in` in 1: single system clock; all logic on its rising edge
- `reset` in 1: synchronous, active-high reset
- `en` in NUM_CH: per-channel run enable
- `sync` in 1: one-cycle strobe; restarts all channels phase-aligned
- `cfg_we` in 1: config write strobe
- `cfg_ch` in 4: target channel index
- `cfg_div` in CNT_W: new divider value
- `cfg_mode` in 1: new mode
- `cfg_pend` out NUM_CH: channel has a written but not yet applied config
- `clk_out` out NUM_CH: toggle-mode square wave (held 0 in pulse mode)
- `tick` out NUM_CH: one-cycle strobe at every terminal count (both modes)

## Operation
- Per channel: active regs `div_a`, `mode_a`; pending regs `div_p`, `mode_p`, flag `pend`; counter `cnt` (CNT_W).
- Enabled channel with `div_a` ≥ 1: `cnt` increments each cycle; when `cnt == div_a-1` (terminal count, TC): `cnt <= 0`, `tick <= 1` for one cycle, and in toggle mode `clk_out <= ~clk_out`.
- Resulting periods: toggle mode 2·`div_a` cycles, high and low each `div_a`; pulse mode `tick` every `div_a` cycles. `div_a = 1`: clk_in/2 square wave or `tick` continuously high.
- `div_a = 0`: channel stalled; `cnt` held at 0, `tick` 0, `clk_out` holds.
- `en` low: `cnt`, `clk_out` hold; `tick` 0. Re-enable resumes from held count, no phase loss.
- Config write: `cfg_we` with `cfg_ch < NUM_CH` loads `div_p`/`mode_p`, sets `pend`. `cfg_ch ≥ NUM_CH` ignored. A second write before apply overwrites pending (last write wins).
- Apply: pending copied to active and `pend` cleared at the channel's TC, or on the next cycle if the channel is disabled or stalled (`div_a = 0`). Apply at TC: counter restarts at 0 with new ratio; the TC's own `tick`/toggle still uses old mode. Switching into pulse mode forces `clk_out <= 0`. Glitch-free: no output edge except at TC.
- `sync`: all channels `cnt <= 0`, `clk_out <= 0`, `tick <= 0`; every pending config applied in that cycle. `cfg_we` in the same cycle as `sync` writes through: targeted channel's active regs take the new value directly, `pend` stays 0.
- `cfg_we` on a channel in the same cycle as its TC: write goes to pending, `pend` = 1; applied at the following TC.

## Timing
- `reset`: `cnt` 0, `div_a` = `div_p` = DEF_DIV, `mode_a` = `mode_p` = DEF_MODE, `pend` 0, `clk_out` 0, `tick` 0. Reset mid-operation discards pending writes. Reset dominates `sync` and `cfg_we`.
- All outputs registered; `tick`/`clk_out` change on the edge where TC is detected (TC is `cnt` = div-1 in the prior cycle).
- First toggle after reset release with `en` high: after exactly `div_a` enabled cycles. `cfg_pend` rises the cycle after `cfg_we`.
- Counter compare is equality on CNT_W bits; no wrap beyond `div_a-1` except if `div_a` shrinks — cannot happen since apply only at TC or from `cnt = 0`.

## Structure
- Shared package/header `clk_div_pkg`: mode constants `MODE_TOGGLE = 0`, `MODE_PULSE = 1`, default divider constants for 480 Hz and 1 kHz at 100 MHz.
- One sub-module `clk_div_ch` (single channel: counter, active/pending regs, outputs), instantiated NUM_CH times by a generate loop; top decodes `cfg_ch` into per-channel write strobes and fans out `sync`.

## Test plan
- Reset, `en = 1`, default config, DIV overridden to 5 → `clk_out[0]` first rises after 5 cycles, period 10, `tick` every 5 cycles.
- Channel 1 pulse mode div 3, channel 2 toggle div 1 → `tick[1]` every 3rd cycle, `clk_out[1]` 0; `clk_out[2]` toggles every cycle.
- Write div 8 to channel 0 at `cnt = 2` (div 5) → `cfg_pend[0]` high until TC at `cnt = 4`, next half period 8 cycles, no short pulse.
- Drop `en[0]` for 7 cycles at `cnt = 3` → `clk_out` holds, `tick` 0; resumes with 1 cycle to TC.
- Pulse `sync` with `cfg_we` to channel 3 (div 4) in same cycle → all counters 0, `clk_out` 0, `cfg_pend` all 0, channel 3 ticks 4 cycles later.
- Write `cfg_ch = 15` with NUM_CH = 4, and div 0 to channel 0 → no state change for the former; channel 0 stalls, outputs hold, pending applies next cycle when rewritten to 2.
